// File: rtl/npu_pkg.sv
// Shared NPU types and constants for the output packing path.
package npu_pkg;

    localparam int NPU_QUANT_W           = 8;
    localparam int NPU_PACK_LANES        = 16;
    localparam int NPU_PACK_FIFO_DEPTH   = 4;
    localparam int NPU_PACK_STALL_MARGIN = 1;

    // One packed output word as it sits in the FIFO; field order matches the
    // flat {data, strb, last} vector used inside the packer.
    typedef struct packed {
        logic [NPU_PACK_LANES*NPU_QUANT_W-1:0] data;
        logic [NPU_PACK_LANES-1:0]             strb;
        logic                                  last;
    } pack_word_t;

    // Flat width of a packed word for an arbitrary lane count / element width.
    function automatic int pack_word_bits(input int lanes, input int elem_w);
        return lanes * elem_w + lanes + 1;
    endfunction

endpackage

// File: rtl/pack_fifo.sv
// First-word-fall-through FIFO holding completed output words.
module pack_fifo #(
    parameter int WIDTH = 145,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Status flags and qualified push/pop; a push into a full FIFO is only
    // taken when the head leaves in the same cycle.
    always_comb begin
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = empty ? '0 : mem[rd_ptr];
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage; stale entries are never visible because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/quant_output_packer.sv
// Packs the quantizer's serial byte stream into LANES-wide words with strobes
// and a tile-end flag, buffered in a small FIFO toward the output writer.
//
// Output handshake: a word transfers on every rising edge where m_valid and
// m_ready are both high. While m_valid is high and m_ready is low, m_data,
// m_strb and m_last hold the same head word and m_valid stays high.
module quant_output_packer
    import npu_pkg::*;
#(
    parameter int IN_WIDTH     = NPU_QUANT_W,
    parameter int LANES        = NPU_PACK_LANES,
    parameter int FIFO_DEPTH   = NPU_PACK_FIFO_DEPTH,
    parameter int STALL_MARGIN = NPU_PACK_STALL_MARGIN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      valid_in,
    input  logic [IN_WIDTH-1:0]       data_in,
    input  logic                      last_in,
    input  logic                      flush,
    output logic                      stall_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANES*IN_WIDTH-1:0] m_data,
    output logic [LANES-1:0]          m_strb,
    output logic                      m_last,
    output logic                      overflow,
    output logic [15:0]               words_out
);

    localparam int LW       = $clog2(LANES);
    localparam int DATA_W   = LANES * IN_WIDTH;
    localparam int WORD_W   = pack_word_bits(LANES, IN_WIDTH);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int STALL_AT = FIFO_DEPTH - STALL_MARGIN;

    logic [LW-1:0]     lane_cnt;
    logic [DATA_W-1:0] pack_q;
    logic [LANES-1:0]  strb_q;
    logic [DATA_W-1:0] pack_nxt;
    logic [LANES-1:0]  strb_nxt;

    logic              complete;
    logic              flush_partial;
    logic              push_req;
    logic              push_last;
    logic              push_ok;
    logic              drop;
    logic              pop;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_next;
    logic [WORD_W-1:0] head;

    logic              stall_q;
    logic              overflow_q;
    logic [15:0]       words_q;

    // Merge the incoming byte into the pack register and decide whether a
    // word leaves this cycle (full word, tile end, or flush).
    always_comb begin
        pack_nxt = pack_q;
        strb_nxt = strb_q;
        if (valid_in) begin
            pack_nxt[lane_cnt*IN_WIDTH +: IN_WIDTH] = data_in;
            strb_nxt[lane_cnt]                      = 1'b1;
        end
        complete      = valid_in && ((lane_cnt == LW'(LANES - 1)) || last_in || flush);
        flush_partial = flush && !valid_in && (lane_cnt != '0);
        push_req      = complete || flush_partial;
        push_last     = last_in || flush;
        pop           = !fifo_empty && m_ready;
        push_ok       = push_req && (!fifo_full || pop);
        drop          = push_req && fifo_full && !pop;
        count_next    = fifo_count + CW'(push_ok) - CW'(pop);
    end

    // Lane counter, pack and strobe registers; a word leaving (pushed or
    // dropped) always restarts packing at lane 0 with zeroed lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            pack_q   <= '0;
            strb_q   <= '0;
        end else if (clear || push_req) begin
            lane_cnt <= '0;
            pack_q   <= '0;
            strb_q   <= '0;
        end else if (valid_in) begin
            lane_cnt <= lane_cnt + 1'b1;
            pack_q   <= pack_nxt;
            strb_q   <= strb_nxt;
        end
    end

    pack_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push_ok),
        .push_data ({pack_nxt, strb_nxt, push_last}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Early stall toward the quantizer, sticky overflow and accepted-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            words_q    <= '0;
        end else if (clear) begin
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            words_q    <= '0;
        end else begin
            stall_q <= (int'(count_next) >= STALL_AT);
            if (drop) overflow_q <= 1'b1;
            if (pop)  words_q    <= words_q + 16'd1;
        end
    end

    // Output stream comes straight from the FIFO head.
    always_comb begin
        m_valid   = !fifo_empty;
        m_data    = head[WORD_W-1 -: DATA_W];
        m_strb    = head[LANES:1];
        m_last    = head[0];
        stall_out = stall_q;
        overflow  = overflow_q;
        words_out = words_q;
    end

endmodule
